// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Single-outstanding-request instruction fetch stage. It keeps the program
//   counter, issues word-aligned read requests to instruction memory, and
//   holds one fetched instruction in an output buffer until the decode stage
//   accepts it. Redirects (branch/jump) discard the buffered instruction and
//   any fetch still in flight. The response of an abandoned fetch is
//   swallowed in S_DROP.
//
// Parameters:
//   RESET_PC     PC value loaded on reset.
//
// Ports:
//   clk          in   1   clock, rising-edge
//   rst          in   1   synchronous active-high reset
//   imem_req     out  1   read request (combinational, one cycle per request)
//   imem_addr    out  32  fetch address (current PC)
//   imem_rdata   in   32  instruction word, valid with imem_ack
//   imem_ack     in   1   read completion
//   redirect     in   1   branch/jump taken
//   redirect_pc  in   32  new PC (low two bits ignored)
//   id_ready     in   1   decode stage accepts the buffered instruction
//   if_valid     out  1   output buffer holds an instruction
//   if_instr     out  32  buffered instruction
//   if_pc        out  32  address of buffered instruction
//   if_pc_plus4  out  32  if_pc + 4 (wraps)
//   instr_op     out  6   if_instr[31:26]
//   fetch_count  out  16  delivered-instruction count
//
// Configuration:
//   FETCH_PERF_CNT_EN  when defined, fetch_count counts transfers to decode
//                      (wrapping); when undefined, fetch_count is tied to 0.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [5:0]  instr_op,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic        transfer;
  logic        load;

  // Decode consumes the buffer; a load only happens when the ack belongs to
  // a live (not redirected) fetch.
  assign transfer = if_valid & id_ready;
  assign load     = (state == S_WAIT) & imem_ack & ~redirect;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ: begin
        // A redirect suppresses imem_req, so the FSM stays here on redirect.
        if (imem_req) begin
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        // An ack always completes the request, whether its data is kept or
        // discarded because of a simultaneous redirect.
        if (imem_ack) begin
          state_nxt = S_REQ;
        end else if (redirect) begin
          state_nxt = S_DROP;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          state_nxt = S_REQ;
        end else begin
          state_nxt = S_DROP;
        end
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  // FSM output logic: request only when the buffer will have room
  always_comb begin
    imem_req = 1'b0;
    if (!rst && (state == S_REQ) && !redirect && (!if_valid || id_ready)) begin
      imem_req = 1'b1;
    end else begin
      imem_req = 1'b0;
    end
  end

  // Program counter: redirect has priority over sequential advance
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= {redirect_pc[31:2], 2'b00};
    end else if (load) begin
      pc <= pc + 32'd4;
    end else begin
      pc <= pc;
    end
  end

  // Output buffer: load beats drain, redirect flushes
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_instr <= 32'h0000_0000;
      if_pc    <= 32'h0000_0000;
    end else if (redirect) begin
      if_valid <= 1'b0;
    end else if (load) begin
      if_valid <= 1'b1;
      if_instr <= imem_rdata;
      if_pc    <= pc;
    end else if (transfer) begin
      if_valid <= 1'b0;
    end else begin
      if_valid <= if_valid;
    end
  end

  assign imem_addr   = pc;
  assign if_pc_plus4 = if_pc + 32'd4;
  assign instr_op    = if_instr[31:26];

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt;

  // Delivered-instruction counter; a transfer during a redirect still counts
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= 16'h0000;
    end else if (transfer) begin
      fetch_cnt <= fetch_cnt + 16'd1;
    end else begin
      fetch_cnt <= fetch_cnt;
    end
  end

  assign fetch_count = fetch_cnt;
`else
  assign fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed testbench for instr_fetch_unit. The stimulus process pushes the
// expected fetch address for every request it intends to provoke, and the
// expected (instr, pc, pc+4, opcode) for every instruction it returns that
// should reach decode. A monitor on the falling edge pops and compares
// whenever imem_req or a buffer transfer appears.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [5:0]  op;
  } xfer_t;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [5:0]  instr_op;
  logic [15:0] fetch_count;

  logic [31:0] aq[$];
  xfer_t       xq[$];
  int          errors = 0;
  int          checks = 0;

  instr_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_ready   (id_ready),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_pc_plus4(if_pc_plus4),
    .instr_op   (instr_op),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input logic [31:0] n);
`ifdef FETCH_PERF_CNT_EN
    return n;
`else
    return 32'd0 & n;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Current cycle must carry the request for addr; the next cycle acks it.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                          input logic [5:0] op, input logic [31:0] pc4);
    xfer_t x;
    aq.push_back(addr);
    step();
    imem_ack   = 1'b1;
    imem_rdata = data;
    x.instr = data;
    x.pc    = addr;
    x.pc4   = pc4;
    x.op    = op;
    xq.push_back(x);
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
  endtask

  // Monitor: compare every request and every transfer against the queues
  always @(negedge clk) begin
    logic [31:0] a;
    xfer_t       x;
    if (rst) begin
      chk("req_during_rst", {31'd0, imem_req}, 32'd0);
    end else begin
      if (imem_req) begin
        if (aq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
        end else begin
          a = aq.pop_front();
          chk("imem_addr", imem_addr, a);
        end
      end
      if (if_valid && id_ready) begin
        if (xq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got instr %h expected no transfer", if_instr);
        end else begin
          x = xq.pop_front();
          chk("if_instr", if_instr, x.instr);
          chk("if_pc", if_pc, x.pc);
          chk("if_pc_plus4", if_pc_plus4, x.pc4);
          chk("instr_op", {26'd0, instr_op}, {26'd0, x.op});
        end
      end
    end
  end

  initial begin
    rst         = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = 32'd0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    id_ready    = 1'b1;
    step();
    step();
    step();
    // Reset state
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_fetch_count", {16'd0, fetch_count}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0000_0000);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b0;

    // Sequential fetch, ack latency 1: addresses 0, 4, 8
    do_fetch(32'h0000_0000, 32'h8C22_0004, 6'd35, 32'h0000_0004);
    do_fetch(32'h0000_0004, 32'h2001_0005, 6'd8,  32'h0000_0008);
    do_fetch(32'h0000_0008, 32'h3C01_1234, 6'd15, 32'h0000_000C);

    // Decode stall: buffer holds, no request
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_if_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_if_instr", if_instr, 32'h3C01_1234);
      chk("stall_imem_req", {31'd0, imem_req}, 32'd0);
      step();
    end
    chk("cnt_after_2", {16'd0, fetch_count}, cnt_exp(32'd2));
    id_ready = 1'b1;
    aq.push_back(32'h0000_000C);
    #1;
    chk("release_imem_req", {31'd0, imem_req}, 32'd1);
    step();
    chk("cnt_after_3", {16'd0, fetch_count}, cnt_exp(32'd3));
    chk("wait_if_valid", {31'd0, if_valid}, 32'd0);

    // Redirect in S_WAIT, stale ack two cycles later is dropped
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    step();
    redirect = 1'b0;
    step();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    chk("drop_if_valid", {31'd0, if_valid}, 32'd0);
    chk("drop_next_addr", imem_addr, 32'h0000_0040);
    do_fetch(32'h0000_0040, 32'h1234_5678, 6'd4, 32'h0000_0044);

    // Transfer coinciding with redirect still counts
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0080;
    step();
    redirect = 1'b0;
    chk("xfer_redir_if_valid", {31'd0, if_valid}, 32'd0);
    chk("xfer_redir_addr", imem_addr, 32'h0000_0080);
    chk("cnt_after_4", {16'd0, fetch_count}, cnt_exp(32'd4));

    // Redirect coinciding with imem_ack: data dropped
    aq.push_back(32'h0000_0080);
    step();
    imem_ack    = 1'b1;
    imem_rdata  = 32'hCAFE_F00D;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    redirect   = 1'b0;
    chk("ack_redir_if_valid", {31'd0, if_valid}, 32'd0);
    chk("ack_redir_addr", imem_addr, 32'h0000_0100);
    do_fetch(32'h0000_0100, 32'hAC43_0008, 6'd43, 32'h0000_0104);

    // Unaligned redirect near top of memory, then wrap to 0
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    chk("align_addr", imem_addr, 32'hFFFF_FFFC);
    chk("align_if_valid", {31'd0, if_valid}, 32'd0);
    do_fetch(32'hFFFF_FFFC, 32'h0800_0010, 6'd2, 32'h0000_0000);
    do_fetch(32'h0000_0000, 32'h0000_0013, 6'd0, 32'h0000_0004);

    // Reset in the middle of a fetch
    aq.push_back(32'h0000_0004);
    step();
    chk("cnt_after_7", {16'd0, fetch_count}, cnt_exp(32'd7));
    rst = 1'b1;
    step();
    chk("rst2_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst2_if_instr", if_instr, 32'd0);
    chk("rst2_if_pc", if_pc, 32'd0);
    chk("rst2_fetch_count", {16'd0, fetch_count}, 32'd0);
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    aq.push_back(32'h0000_0000);
    #1;
    chk("rst2_imem_addr", imem_addr, 32'h0000_0000);
    chk("rst2_imem_req", {31'd0, imem_req}, 32'd1);
    step();
    chk("stale_ack_if_valid", {31'd0, if_valid}, 32'd0);
    imem_rdata = 32'h8C22_0004;
    begin
      xfer_t x;
      x.instr = 32'h8C22_0004;
      x.pc    = 32'h0000_0000;
      x.pc4   = 32'h0000_0004;
      x.op    = 6'd35;
      xq.push_back(x);
    end
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    aq.push_back(32'h0000_0004);
    step();
    chk("cnt_after_rst", {16'd0, fetch_count}, cnt_exp(32'd1));
    step();
    step();
    step();
    chk("addr_queue_empty", aq.size(), 32'd0);
    chk("xfer_queue_empty", xq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
